// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock-step controller: board mode switch
// values, controller FSM states and the mode-to-state mapping.
package cpu_clk_pkg;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;
  localparam logic [1:0] MODE_FAST = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_STEP = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } ctrl_state_t;

  // State the controller settles in for a given switch setting when no
  // halt is latched. Both run speeds share the RUN state.
  function automatic ctrl_state_t modeToState(input logic [1:0] m);
    ctrl_state_t s;
    case (m)
      MODE_HALT: s = ST_IDLE;
      MODE_STEP: s = ST_STEP;
      default:   s = ST_RUN;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cpu_clk_step_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, stability window and a
// single-cycle pulse for each accepted low-to-high level change.
module step_debouncer
  import cpu_clk_pkg::*;
#(
  parameter int DEBOUNCE = 500000
) (
  input  logic clk50Mhz,
  input  logic rstN,
  input  logic btnIn,
  output logic pressOut
);

  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

  logic            btnMeta_p0;
  logic            btnSync_p1;
  logic            stableLvl;
  logic [DB_W-1:0] dbCnt;

  // Bring the raw button into the clock domain through two flops.
  always_ff @(posedge clk50Mhz or negedge rstN) begin
    if (!rstN) begin
      btnMeta_p0 <= 1'b0;
      btnSync_p1 <= 1'b0;
    end else begin
      btnMeta_p0 <= btnIn;
      btnSync_p1 <= btnMeta_p0;
    end
  end

  // Count consecutive cycles the synced level differs from the accepted
  // level; any return to the accepted level restarts the window. When the
  // window fills the new level is accepted, pulsing only on a press.
  always_ff @(posedge clk50Mhz or negedge rstN) begin
    if (!rstN) begin
      stableLvl <= 1'b0;
      dbCnt     <= '0;
      pressOut  <= 1'b0;
    end else begin
      pressOut <= 1'b0;
      if (btnSync_p1 == stableLvl) begin
        dbCnt <= '0;
      end else if (dbCnt == DB_LAST) begin
        stableLvl <= btnSync_p1;
        dbCnt     <= '0;
        pressOut  <= btnSync_p1;
      end else begin
        dbCnt <= dbCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_clk_step_ctrl.sv
// CPU execution-rate sequencer. Produces a one-cycle enable strobe (cpuEn)
// from the 50 MHz board clock in halt, single-step, slow-run and fast-run
// modes, with a CPU-driven halt latch. No derived clocks are generated.
// Optional build macro STEP_COUNT_EN adds a 32-bit strobe counter on
// stepCount; without it stepCount is tied to zero.
module cpu_clk_step_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int FAST_DIV = 100000,
  parameter int SLOW_DIV = 25000000,
  parameter int DEBOUNCE = 500000,
  parameter int CNT_W    = 27
) (
  input  logic        clk50Mhz,
  input  logic        rstN,
  input  logic [1:0]  mode,
  input  logic        stepBtn,
  input  logic        cpuHalt,
  output logic        cpuEn,
  output logic        tickLed,
  output logic        halted,
  output logic [1:0]  state,
  output logic [31:0] stepCount
);

  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);

  logic [1:0]       modeMeta_p0;
  logic [1:0]       modeSync_p1;
  logic [1:0]       modeReg_p2;
  logic             modeChg;
  ctrl_state_t      curState;
  ctrl_state_t      nextState;
  logic             haltLatch;
  logic             nextHalt;
  logic [CNT_W-1:0] divCnt;
  logic [CNT_W-1:0] divLast;
  logic             pressOut;
  logic             runDue;
  logic             stepDue;
  logic             strobeDue;

  step_debouncer #(
    .DEBOUNCE (DEBOUNCE)
  ) uDebounce (
    .clk50Mhz (clk50Mhz),
    .rstN     (rstN),
    .btnIn    (stepBtn),
    .pressOut (pressOut)
  );

  // Synchronize the mode switch and keep a registered copy for change detect.
  always_ff @(posedge clk50Mhz or negedge rstN) begin
    if (!rstN) begin
      modeMeta_p0 <= MODE_HALT;
      modeSync_p1 <= MODE_HALT;
      modeReg_p2  <= MODE_HALT;
    end else begin
      modeMeta_p0 <= mode;
      modeSync_p1 <= modeMeta_p0;
      modeReg_p2  <= modeSync_p1;
    end
  end

  assign modeChg = (modeSync_p1 != modeReg_p2);
  assign divLast = (modeReg_p2 == MODE_FAST) ? FAST_LAST : SLOW_LAST;

  // The strobe slot is dropped on a mode change (the counter restarts) and
  // when the CPU asks to halt in the same cycle. The guard on cpuEn keeps
  // strobes from ever landing on adjacent cycles.
  assign runDue    = (curState == ST_RUN) && !modeChg && !cpuHalt && (divCnt == divLast);
  assign stepDue   = pressOut && ((curState == ST_STEP) || (curState == ST_HALT));
  assign strobeDue = (runDue || stepDue) && !cpuEn;

  // FSM state and halt latch registers.
  always_ff @(posedge clk50Mhz or negedge rstN) begin
    if (!rstN) begin
      curState  <= ST_IDLE;
      haltLatch <= 1'b0;
    end else begin
      curState  <= nextState;
      haltLatch <= nextHalt;
    end
  end

  // Next-state logic: HALT is left only by a mode change; RUN drops into
  // HALT whenever the CPU raises its halt request.
  always_comb begin
    nextState = curState;
    nextHalt  = haltLatch;
    case (curState)
      ST_HALT: begin
        if (modeChg) begin
          nextHalt  = 1'b0;
          nextState = modeToState(modeSync_p1);
        end
      end
      ST_RUN: begin
        if (cpuHalt) begin
          nextHalt  = 1'b1;
          nextState = ST_HALT;
        end else begin
          nextState = modeToState(modeSync_p1);
        end
      end
      default: begin
        nextState = modeToState(modeSync_p1);
      end
    endcase
  end

  // Divide counter: runs 0..DIV-1 only in RUN, otherwise parked at zero,
  // and restarts from zero after any mode change.
  always_ff @(posedge clk50Mhz or negedge rstN) begin
    if (!rstN) begin
      divCnt <= '0;
    end else if (modeChg || (curState != ST_RUN) || cpuHalt || (divCnt == divLast)) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + 1'b1;
    end
  end

  // Registered strobe and the LED that toggles once per strobe.
  always_ff @(posedge clk50Mhz or negedge rstN) begin
    if (!rstN) begin
      cpuEn   <= 1'b0;
      tickLed <= 1'b0;
    end else begin
      cpuEn   <= strobeDue;
      tickLed <= tickLed ^ cpuEn;
    end
  end

  assign halted = haltLatch;
  assign state  = curState;

`ifdef STEP_COUNT_EN
  logic [31:0] stepCnt;

  // Free-running count of issued strobes, wrapping naturally at 2^32.
  always_ff @(posedge clk50Mhz or negedge rstN) begin
    if (!rstN) begin
      stepCnt <= '0;
    end else if (cpuEn) begin
      stepCnt <= stepCnt + 32'd1;
    end
  end

  assign stepCount = stepCnt;
`else
  assign stepCount = '0;
`endif

endmodule
